btb_resolve: RTL and testbench

- Resolve-side partner of the fetch-stage branch target buffer. Sits at the end of the execute stage.
- Compares each resolved branch against the prediction made at fetch. On a mispredict it issues a registered redirect and flush to fetch.
- Queues BTB write-backs (pc, target, op) in a small FIFO and drains them to the BTB update port under a valid/ready handshake.
- Keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/btb_resolve_pkg.sv | 36 +++
 rtl/btb_upd_fifo.sv | 65 ++++++
 rtl/btb_resolve.sv | 165 ++++++++++++++++
 tb/tb_btb_resolve.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/btb_resolve_pkg.sv
// Shared types for the resolve-side BTB logic: LC-3b word, BTB write-back
// record, resolve FSM states and the mispredict classification helpers.
package btb_resolve_pkg;

    typedef logic [15:0] lc3b_word;

    typedef struct packed {
        lc3b_word    pc;
        lc3b_word    target;
        logic [3:0]  op;
    } lc3b_btb_upd;

    // Prefixed so the SHADOW literal cannot collide with the SHADOW parameter.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SHADOW   = 2'd2
    } btb_resolve_state_t;

    localparam lc3b_word PC_STEP = 16'd2;

    // Taken branch whose target the BTB did not supply correctly; also the
    // only case that earns a BTB write-back.
    function automatic logic wrong_target(input logic     taken,
                                          input logic     hit,
                                          input lc3b_word pred,
                                          input lc3b_word actual);
        return taken & (~hit | (pred != actual));
    endfunction

    function automatic logic wrong_direction(input logic taken,
                                             input logic hit);
        return ~taken & hit;
    endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Synchronous FIFO of BTB write-back records with a zero-latency head.
// A push while full is ignored unless a pop happens in the same cycle.
module btb_upd_fifo
    import btb_resolve_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  lc3b_btb_upd push_data,
    output logic        full,
    input  logic        pop,
    output logic        empty,
    output lc3b_btb_upd head
);

    localparam int PW = $clog2(DEPTH);

    lc3b_btb_upd    mem_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [PW:0]    count_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign empty     = (count_r == (PW+1)'(0));
    assign full      = (count_r == (PW+1)'(DEPTH));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign head      = mem_r[rd_ptr_r];

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Occupancy, one bit wider than the pointers to tell full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/btb_resolve.sv
// Execute-stage branch resolution: detects BTB mispredicts, issues a
// registered redirect/flush, queues BTB write-backs and counts branches.
module btb_resolve
    import btb_resolve_pkg::*;
#(
    parameter int UPD_DEPTH = 4,
    parameter int SHADOW    = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             resolve_valid,
    input  logic [15:0]      resolve_pc,
    input  logic             resolve_taken,
    input  logic [15:0]      resolve_target,
    input  logic [3:0]       resolve_op,
    input  logic             pred_hit,
    input  logic [15:0]      pred_target,
    output logic             redirect,
    output logic [15:0]      redirect_pc,
    output logic             flush,
    output logic             update,
    input  logic             update_ready,
    output logic [15:0]      update_pc,
    output logic [15:0]      update_target,
    output logic [3:0]       update_op,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int SW = (SHADOW > 1) ? $clog2(SHADOW) : 1;

    btb_resolve_state_t state_r;
    btb_resolve_state_t state_s;
    logic [SW-1:0]      shadow_cnt_r;
    logic [SW-1:0]      shadow_cnt_s;

    logic               accept_s;
    logic               bad_target_s;
    logic               mispredict_s;
    logic               push_s;
    lc3b_word           fix_pc_s;
    lc3b_btb_upd        push_data_s;
    lc3b_btb_upd        head_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    logic               redirect_r;
    logic               flush_r;
    lc3b_word           redirect_pc_r;
    logic [CNT_W-1:0]   branch_count_r;
    logic [CNT_W-1:0]   mispredict_count_r;

    assign accept_s     = resolve_valid & ~stall & (state_r != ST_SHADOW);
    assign bad_target_s = wrong_target(resolve_taken, pred_hit, pred_target, resolve_target);
    assign mispredict_s = accept_s &
                          (bad_target_s | wrong_direction(resolve_taken, pred_hit));
    // Dropping on full is acceptable: the BTB is only a hint.
    assign push_s       = accept_s & bad_target_s & (~fifo_full_s | update_ready);
    assign fix_pc_s     = resolve_taken ? resolve_target : (resolve_pc + PC_STEP);

    assign push_data_s.pc     = resolve_pc;
    assign push_data_s.target = resolve_target;
    assign push_data_s.op     = resolve_op;

    btb_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_data_s),
        .full      (fifo_full_s),
        .pop       (update_ready),
        .empty     (fifo_empty_s),
        .head      (head_s)
    );

    // Next-state logic; a mispredict seen in REDIRECT restarts the redirect.
    always_comb begin
        state_s      = state_r;
        shadow_cnt_s = shadow_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (mispredict_s) begin
                    state_s = ST_REDIRECT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (mispredict_s) begin
                    state_s = ST_REDIRECT;
                end else begin
                    state_s      = ST_SHADOW;
                    shadow_cnt_s = SW'(SHADOW - 1);
                end
            end
            ST_SHADOW: begin
                if (shadow_cnt_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    shadow_cnt_s = shadow_cnt_r - SW'(1);
                end
            end
            default: begin
                state_s      = ST_IDLE;
                shadow_cnt_s = '0;
            end
        endcase
    end

    // FSM state and wrong-path shadow counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            shadow_cnt_r <= '0;
        end else begin
            state_r      <= state_s;
            shadow_cnt_r <= shadow_cnt_s;
        end
    end

    // Redirect/flush pulse the cycle after the mispredicting accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_r    <= 1'b0;
            flush_r       <= 1'b0;
            redirect_pc_r <= 16'h0000;
        end else begin
            redirect_r <= mispredict_s;
            flush_r    <= mispredict_s;
            if (mispredict_s) begin
                redirect_pc_r <= fix_pc_s;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count_r     <= '0;
            mispredict_count_r <= '0;
        end else begin
            if (accept_s && (branch_count_r != '1)) begin
                branch_count_r <= branch_count_r + CNT_W'(1);
            end
            if (mispredict_s && (mispredict_count_r != '1)) begin
                mispredict_count_r <= mispredict_count_r + CNT_W'(1);
            end
        end
    end

    assign redirect         = redirect_r;
    assign flush            = flush_r;
    assign redirect_pc      = redirect_pc_r;
    assign branch_count     = branch_count_r;
    assign mispredict_count = mispredict_count_r;
    assign update           = ~fifo_empty_s;
    assign update_pc        = head_s.pc;
    assign update_target    = head_s.target;
    assign update_op        = head_s.op;

endmodule

// File: tb/tb_btb_resolve.sv
// Scoreboard bench for btb_resolve: a cycle-indexed reference model queues
// expected redirects and BTB write-backs; a negedge monitor checks them.
module tb_btb_resolve;

    localparam int DEPTH = 4;
    localparam int SHAD  = 2;

    typedef struct {
        int          cyc;
        logic [15:0] pc;
    } rdr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        resolve_valid = 1'b0;
    logic [15:0] resolve_pc = 16'h0;
    logic        resolve_taken = 1'b0;
    logic [15:0] resolve_target = 16'h0;
    logic [3:0]  resolve_op = 4'h0;
    logic        pred_hit = 1'b0;
    logic [15:0] pred_target = 16'h0;
    logic        update_ready = 1'b0;

    logic        redirect, flush, update;
    logic [15:0] redirect_pc, update_pc, update_target;
    logic [3:0]  update_op;
    logic [15:0] branch_count, mispredict_count;

    logic        redirect_n, flush_n, update_n;
    logic [15:0] redirect_pc_n, update_pc_n, update_target_n;
    logic [3:0]  update_op_n;
    logic [3:0]  branch_count_n, mispredict_count_n;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          cyc = 0;
    int          last_mp = -1000;
    int          bc = 0;
    int          mc = 0;
    logic [35:0] mq[$];
    logic [35:0] upd_exp[$];
    rdr_t        rdr_q[$];
    // Snapshot of what the DUT should show during the current cycle
    logic        exp_upd_valid = 1'b0;
    int          exp_bc = 0;
    int          exp_mc = 0;

    always #5 clk = ~clk;

    btb_resolve dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .resolve_valid(resolve_valid),
        .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_op(resolve_op),
        .pred_hit(pred_hit), .pred_target(pred_target),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
        .update(update), .update_ready(update_ready), .update_pc(update_pc),
        .update_target(update_target), .update_op(update_op),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    btb_resolve #(.CNT_W(4)) dut_n (
        .clk(clk), .rst_n(rst_n), .stall(stall), .resolve_valid(resolve_valid),
        .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_target(resolve_target), .resolve_op(resolve_op),
        .pred_hit(pred_hit), .pred_target(pred_target),
        .redirect(redirect_n), .redirect_pc(redirect_pc_n), .flush(flush_n),
        .update(update_n), .update_ready(update_ready), .update_pc(update_pc_n),
        .update_target(update_target_n), .update_op(update_op_n),
        .branch_count(branch_count_n), .mispredict_count(mispredict_count_n)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit in_shadow(input int c);
        return (c >= last_mp + 2) && (c <= last_mp + 1 + SHAD);
    endfunction

    // One clock of stimulus; the model applies what the coming edge should do.
    task automatic drive_cycle(input logic v, input logic st, input logic [15:0] pc,
                               input logic tk, input logic [15:0] tg, input logic [3:0] op,
                               input logic hit, input logic [15:0] pt, input logic rdy);
        logic        wt, wd;
        logic [15:0] next_pc;
        @(posedge clk);
        #1;
        cyc++;
        exp_upd_valid = (mq.size() > 0);
        exp_bc = bc;
        exp_mc = mc;
        resolve_valid = v; stall = st; resolve_pc = pc; resolve_taken = tk;
        resolve_target = tg; resolve_op = op; pred_hit = hit; pred_target = pt;
        update_ready = rdy;
        if ((mq.size() > 0) && rdy) void'(mq.pop_front());
        if (v && !st && !in_shadow(cyc)) begin
            bc++;
            wt = tk && (!hit || (pt != tg));
            wd = !tk && hit;
            if (wt || wd) begin
                mc++;
                last_mp = cyc;
                next_pc = pc + 16'd2;
                rdr_q.push_back('{cyc + 1, wt ? tg : next_pc});
            end
            if (wt && (mq.size() < DEPTH)) begin
                mq.push_back({pc, tg, op});
                upd_exp.push_back({pc, tg, op});
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, rdy);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_redirect"}, {redirect, flush, redirect_n, flush_n}, 32'h0);
        check({tag, "_rpc"}, {redirect_pc, redirect_pc_n}, 32'h0);
        check({tag, "_update"}, {update, update_n}, 32'h0);
        check({tag, "_head"}, {update_pc, update_target}, 32'h0);
        check({tag, "_op"}, {update_op, update_op_n}, 32'h0);
        check({tag, "_counts"}, {branch_count, mispredict_count}, 32'h0);
        check({tag, "_counts_n"}, {branch_count_n, mispredict_count_n}, 32'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        resolve_valid = 1'b0; stall = 1'b0; update_ready = 1'b0;
        #1;
        check_zero_outputs("rst");
        mq.delete(); upd_exp.delete(); rdr_q.delete();
        bc = 0; mc = 0; last_mp = -1000;
        exp_upd_valid = 1'b0; exp_bc = 0; exp_mc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compares every visible output against the scoreboard.
    always @(negedge clk) begin
        logic        exp_now;
        logic [35:0] e;
        if (rst_n) begin
            exp_now = (rdr_q.size() > 0) && (rdr_q[0].cyc == cyc);
            check("redirect", redirect, exp_now);
            check("flush", flush, exp_now);
            check("redirect_n", redirect_n & flush_n, exp_now);
            if (exp_now) begin
                check("redirect_pc", redirect_pc, rdr_q[0].pc);
                check("redirect_pc_n", redirect_pc_n, rdr_q[0].pc);
                void'(rdr_q.pop_front());
            end
            check("update", update, exp_upd_valid);
            check("update_n", update_n, exp_upd_valid);
            if (update && update_ready) begin
                if (upd_exp.size() == 0) begin
                    check("upd_spurious", 32'd1, 32'd0);
                end else begin
                    e = upd_exp.pop_front();
                    check("upd_pc", update_pc, e[35:20]);
                    check("upd_target", update_target, e[19:4]);
                    check("upd_op", update_op, e[3:0]);
                    check("upd_head_n", {update_pc_n, update_target_n}, e[35:4]);
                end
            end
            check("branch_count", branch_count, sat(exp_bc, 65535));
            check("mispredict_count", mispredict_count, sat(exp_mc, 65535));
            check("branch_count_n", branch_count_n, sat(exp_bc, 15));
            check("mispredict_count_n", mispredict_count_n, sat(exp_mc, 15));
        end
    end

    initial begin
        logic [15:0] pc, tg, pt;
        do_reset();
        check_zero_outputs("post_rst");

        // Saturation: 17 correct not-taken resolves
        for (int i = 0; i < 17; i++)
            drive_cycle(1'b1, 1'b0, 16'h2000 + 16'(i * 2), 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 1'b1);
        idle(1, 1'b1);
        @(negedge clk);
        check("sat_small", branch_count_n, 32'hF);
        check("sat_wide", branch_count, 32'd17);

        // Cold miss, held in the FIFO for a few cycles before popping
        drive_cycle(1'b1, 1'b0, 16'h3000, 1'b1, 16'h3040, 4'h0, 1'b0, 16'h0, 1'b0);
        idle(4, 1'b0);
        idle(2, 1'b1);
        // Correct prediction
        drive_cycle(1'b1, 1'b0, 16'h3000, 1'b1, 16'h3040, 4'h0, 1'b1, 16'h3040, 1'b1);
        idle(2, 1'b1);
        // Not-taken with BTB hit at the top of memory
        drive_cycle(1'b1, 1'b0, 16'hFFFE, 1'b0, 16'h1234, 4'h1, 1'b1, 16'h1234, 1'b1);
        idle(4, 1'b1);

        // Shadow squash: N mispredicts, N+1 evaluated, N+2..N+3 dropped, N+4 counted
        drive_cycle(1'b1, 1'b0, 16'h4000, 1'b1, 16'h4100, 4'h2, 1'b0, 16'h0, 1'b1);
        drive_cycle(1'b1, 1'b0, 16'h4002, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 1'b1);
        drive_cycle(1'b1, 1'b0, 16'h4004, 1'b1, 16'h5000, 4'h3, 1'b0, 16'h0, 1'b1);
        drive_cycle(1'b1, 1'b0, 16'h4006, 1'b0, 16'h0, 4'h0, 1'b1, 16'h0, 1'b1);
        drive_cycle(1'b1, 1'b0, 16'h4008, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 1'b1);
        idle(4, 1'b1);

        // FIFO full: five write-backs while the BTB port is blocked
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 16'h1000 + 16'(i * 16), 1'b1, 16'h6000 + 16'(i * 4),
                        4'(i + 4), 1'b0, 16'h0, 1'b0);
            idle(3, 1'b0);
        end
        idle(8, 1'b1);

        // Reset while two entries are queued and the FSM sits in SHADOW
        drive_cycle(1'b1, 1'b0, 16'h7000, 1'b1, 16'h7100, 4'h9, 1'b0, 16'h0, 1'b0);
        idle(4, 1'b0);
        drive_cycle(1'b1, 1'b0, 16'h7010, 1'b1, 16'h7200, 4'hA, 1'b0, 16'h0, 1'b0);
        idle(1, 1'b0);
        do_reset();
        drive_cycle(1'b1, 1'b0, 16'h7020, 1'b1, 16'h7300, 4'hB, 1'b0, 16'h0, 1'b0);
        idle(4, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            pc = 16'($urandom);
            tg = 16'($urandom);
            pt = ($urandom_range(0, 1) == 0) ? tg : 16'($urandom);
            drive_cycle($urandom_range(0, 9) < 6, $urandom_range(0, 4) == 0, pc,
                        1'($urandom), tg, 4'($urandom), 1'($urandom), pt,
                        $urandom_range(0, 2) != 0);
        end
        idle(12, 1'b1);
        @(negedge clk);
        check("upd_drained", upd_exp.size(), 32'd0);
        check("rdr_drained", rdr_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
